// File: rtl/sme_filter_feeder.sv
// Packs a 64-bit backpressured packet stream into 256-bit beats for the SME
// shift-or filter, generating its init pulse and enforcing inter-packet spacing.
module sme_filter_feeder #(
    parameter int MIN_GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [2:0]   s_empty,
    output logic [255:0] out_data,
    output logic         out_valid,
    output logic         out_init,
    output logic         out_last,
    output logic [4:0]   out_empty
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [255:0]  acc_q, acc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [255:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [4:0]    out_empty_q, out_empty_d;

    logic [63:0]   word_m;
    logic [255:0]  merged;
    logic [7:0]    slot_base;

    assign slot_base = {cnt_q, 6'd0};

    // Bytes beyond the valid payload of the final word are forced to zero.
    always_comb begin
        word_m = s_data;
        for (int unsigned b = 0; b < 8; b++) begin
            if (s_last && (b + 32'(s_empty)) >= 32'd8) begin
                word_m[8*b +: 8] = '0;
            end
        end
        merged = acc_q;
        merged[slot_base +: 64] = word_m;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gap_d       = gap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_empty_d = '0;
        case (state_q)
            S_IDLE: begin
                if (s_valid && gap_q == '0) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: state_d = S_FILL;
            S_FILL: begin
                if (s_valid) begin
                    if (s_last || cnt_q == 2'd3) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged;
                        acc_d       = '0;
                        cnt_d       = '0;
                        if (s_last) begin
                            out_last_d  = 1'b1;
                            out_empty_d = {~cnt_q, s_empty};
                            state_d     = S_GAP;
                            gap_d       = GAP_LOAD;
                        end
                    end else begin
                        acc_d[slot_base +: 64] = s_data;
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                // Counter reaches zero at L+MIN_GAP-1 so init lands at L+MIN_GAP.
                if (gap_q == '0) begin
                    state_d = s_valid ? S_INIT : S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            gap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_empty_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign s_ready   = (state_q == S_FILL);
    assign out_init  = (state_q == S_INIT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_empty = out_empty_q;

endmodule
